// File: rtl/sram_pkg.sv
// Shared definitions for the serial-to-SRAM command path: opcodes, FSM states, widths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sram_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 32;

  localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] OP_READ  = 8'h52;  // 'R'

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_ISSUE,
    ST_WAIT_RD,
    ST_SEND
  } state_t;

endpackage

// File: rtl/sram_cmd_parser.sv
// Assembles serial bytes into SRAM write/read commands and streams read data back as 4 bytes.
// Latency: req rises 1 cycle after the last command byte; tx_valid rises 1 cycle after rvalid.
// Backpressure: req held until ack; tx byte held until tx_ready; bytes arriving while busy are dropped with err.
//
// Ports:
//   clk, xrst                   clock, async active-low reset
//   rx_data, rx_changed         received byte + 1-cycle strobe
//   req, we, addr, wdata, ack   SRAM request (held until ack)
//   rdata, rvalid               SRAM read data + 1-cycle strobe
//   tx_data, tx_valid, tx_ready byte stream to the transmitter
//   err                         1-cycle pulse: unknown opcode or overrun
module sram_cmd_parser #(
  parameter int ADDR_W = sram_pkg::ADDR_W,
  parameter int DATA_W = sram_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic [7:0]        rx_data,
  input  logic              rx_changed,
  output logic              req,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic              ack,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              err
);
  import sram_pkg::*;

  state_t            r_state;
  logic              r_is_wr;
  logic [1:0]        r_cnt;    // byte index, reused by ADDR, DATA and SEND
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rsh;    // read data, shifted left one byte per transfer
  logic              r_tx_vld;
  logic              r_err;

  logic w_is_op;
  logic w_tx_fire;

  assign w_is_op   = (rx_data == OP_WRITE) || (rx_data == OP_READ);
  assign w_tx_fire = r_tx_vld && tx_ready;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_state  <= ST_IDLE;
      r_is_wr  <= 1'b0;
      r_cnt    <= 2'd0;
      r_req    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rsh    <= '0;
      r_tx_vld <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (rx_changed) begin
            if (w_is_op) begin
              r_is_wr <= (rx_data == OP_WRITE);
              r_cnt   <= 2'd0;
              r_state <= ST_ADDR;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_ADDR: begin
          if (rx_changed) begin
            // Shifting through an ADDR_W-wide register drops the unused top bits of the 24.
            r_addr <= {r_addr[ADDR_W-9:0], rx_data};
            r_cnt  <= r_cnt + 2'd1;
            if (r_cnt == 2'd2) begin
              r_cnt <= 2'd0;
              if (r_is_wr) begin
                r_state <= ST_DATA;
              end else begin
                r_req   <= 1'b1;
                r_state <= ST_ISSUE;
              end
            end
          end
        end
        ST_DATA: begin
          if (rx_changed) begin
            r_wdata <= {r_wdata[DATA_W-9:0], rx_data};
            r_cnt   <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_req   <= 1'b1;
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          r_err <= rx_changed;
          if (ack) begin
            r_req <= 1'b0;
            if (r_is_wr) begin
              r_state <= ST_IDLE;
            end else if (rvalid) begin
              // Read data may come back in the same cycle as the ack.
              r_rsh    <= rdata;
              r_tx_vld <= 1'b1;
              r_cnt    <= 2'd0;
              r_state  <= ST_SEND;
            end else begin
              r_state <= ST_WAIT_RD;
            end
          end
        end
        ST_WAIT_RD: begin
          r_err <= rx_changed;
          if (rvalid) begin
            r_rsh    <= rdata;
            r_tx_vld <= 1'b1;
            r_cnt    <= 2'd0;
            r_state  <= ST_SEND;
          end
        end
        ST_SEND: begin
          r_err <= rx_changed;
          if (w_tx_fire) begin
            r_rsh <= r_rsh << 8;
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_tx_vld <= 1'b0;
              r_state  <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req      = r_req;
  assign we       = r_is_wr;
  assign addr     = r_addr;
  assign wdata    = r_wdata;
  assign tx_data  = r_rsh[DATA_W-1 -: 8];
  assign tx_valid = r_tx_vld;
  assign err      = r_err;

endmodule
